// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit with a register-file write-back port.
// One shift-add (multiply) or restoring shift-subtract (divide) step per clock.
// A full operation takes WIDTH step cycles plus one DONE cycle. Divide by zero
// skips straight to DONE with a fixed result.
module muldiv_unit #(
    parameter int WIDTH = 16,
    parameter int RW    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [RW-1:0]    dest_in,
    input  logic [WIDTH-1:0] op0,
    input  logic [WIDTH-1:0] op1,
    output logic             busy,
    output logic             w_en,
    output logic [RW-1:0]    DEST,
    output logic [WIDTH-1:0] w_in,
    output logic [WIDTH-1:0] hi,
    output logic             dz
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_next;

    // Shared iteration registers.
    // Multiply: acc = running high word, lo = multiplier shifting out LSB-first,
    //           opnd = multiplicand.
    // Divide:   acc = partial remainder, lo = dividend shifting out MSB-first
    //           while quotient bits shift in, opnd = divisor.
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   lo;
    logic [WIDTH-1:0]   opnd;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] step_res;
    logic               last_step;

    // One multiply step: conditionally add the multiplicand into the high word,
    // then shift the whole {carry, acc, lo} right by one. After WIDTH steps
    // {acc, lo} holds the full product.
    function automatic logic [2*WIDTH-1:0] mul_step(
        input logic [WIDTH-1:0] acc_in,
        input logic [WIDTH-1:0] lo_in,
        input logic [WIDTH-1:0] mcand
    );
        logic [WIDTH:0] sum;
        sum = {1'b0, acc_in} + (lo_in[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
        return {sum[WIDTH:1], sum[0], lo_in[WIDTH-1:1]};
    endfunction

    // One restoring divide step: bring in the next dividend bit, try to subtract
    // the divisor, keep the difference only when it did not borrow. The borrow
    // shows up in bit WIDTH because the partial remainder is always below the
    // divisor before the shift.
    function automatic logic [2*WIDTH-1:0] div_step(
        input logic [WIDTH-1:0] rem_in,
        input logic [WIDTH-1:0] quo_in,
        input logic [WIDTH-1:0] dvsr
    );
        logic [WIDTH:0] shifted;
        logic [WIDTH:0] diff;
        shifted = {rem_in, quo_in[WIDTH-1]};
        diff    = shifted - {1'b0, dvsr};
        if (!diff[WIDTH]) begin
            return {diff[WIDTH-1:0], quo_in[WIDTH-2:0], 1'b1};
        end else begin
            return {shifted[WIDTH-1:0], quo_in[WIDTH-2:0], 1'b0};
        end
    endfunction

    // Select the step result for the current operation.
    always_comb begin
        step_res = mul_step(acc, lo, opnd);
        if (state == DIV) begin
            step_res = div_step(acc, lo, opnd);
        end
    end

    assign last_step = (cnt == CNT_LAST);

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and busy decode.
    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) begin
                    if (!op) begin
                        state_next = MUL;
                    end else if (op1 == '0) begin
                        state_next = DONE;
                    end else begin
                        state_next = DIV;
                    end
                end
            end
            MUL, DIV: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Write-back pulse: high exactly in the cycle the FSM sits in DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_en <= 1'b0;
        end else begin
            w_en <= (state_next == DONE);
        end
    end

    // Operand capture, iteration and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc  <= '0;
            lo   <= '0;
            opnd <= '0;
            cnt  <= '0;
            DEST <= '0;
            w_in <= '0;
            hi   <= '0;
            dz   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        DEST <= dest_in;
                        cnt  <= '0;
                        acc  <= '0;
                        dz   <= 1'b0;
                        if (!op) begin
                            lo   <= op1;
                            opnd <= op0;
                        end else if (op1 == '0) begin
                            // Divide by zero: all-ones quotient, dividend as remainder.
                            w_in <= '1;
                            hi   <= op0;
                            dz   <= 1'b1;
                        end else begin
                            lo   <= op0;
                            opnd <= op1;
                        end
                    end
                end
                MUL, DIV: begin
                    {acc, lo} <= step_res;
                    cnt       <= cnt + CW'(1);
                    if (last_step) begin
                        {hi, w_in} <= step_res;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: expected results are pushed to a scoreboard
// when a request is driven and compared when w_en pulses.
module tb_muldiv_unit;

    localparam int WIDTH = 16;
    localparam int RW    = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             op;
    logic [RW-1:0]    dest_in;
    logic [WIDTH-1:0] op0;
    logic [WIDTH-1:0] op1;
    logic             busy;
    logic             w_en;
    logic [RW-1:0]    DEST;
    logic [WIDTH-1:0] w_in;
    logic [WIDTH-1:0] hi;
    logic             dz;

    muldiv_unit #(.WIDTH(WIDTH), .RW(RW)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .dest_in(dest_in),
        .op0(op0), .op1(op1), .busy(busy), .w_en(w_en), .DEST(DEST),
        .w_in(w_in), .hi(hi), .dz(dz)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [RW-1:0]    dest;
        logic [WIDTH-1:0] w;
        logic [WIDTH-1:0] h;
        logic             z;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic [RW-1:0] d);
        exp_t e;
        logic [2*WIDTH-1:0] p;
        e.dest = d;
        if (!o) begin
            p   = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
            e.w = p[WIDTH-1:0];
            e.h = p[2*WIDTH-1:WIDTH];
            e.z = 1'b0;
        end else if (b == 0) begin
            e.w = {WIDTH{1'b1}};
            e.h = a;
            e.z = 1'b1;
        end else begin
            e.w = a / b;
            e.h = a % b;
            e.z = 1'b0;
        end
        sb.push_back(e);
    endtask

    // Drive a request from #1 after an edge, accept it on the next edge, then
    // scramble the inputs so any late sampling would corrupt the result.
    task automatic issue(input logic o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [RW-1:0] d);
        start   = 1'b1;
        op      = o;
        op0     = a;
        op1     = b;
        dest_in = d;
        push_exp(o, a, b, d);
        @(posedge clk); #1;
        start   = 1'b0;
        op      = 1'($urandom);
        op0     = WIDTH'($urandom);
        op1     = WIDTH'($urandom);
        dest_in = RW'($urandom);
    endtask

    task automatic check_result(input string tag);
        exp_t e;
        check({tag, "_wen"}, 32'(w_en), 32'd1);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        check({tag, "_dest"}, 32'(DEST), 32'(e.dest));
        check({tag, "_w_in"}, 32'(w_in), 32'(e.w));
        check({tag, "_hi"},   32'(hi),   32'(e.h));
        check({tag, "_dz"},   32'(dz),   32'(e.z));
    endtask

    // Wait (bounded) for w_en, starting lat0 edges after the accept edge.
    task automatic wait_result(input string tag, input int exp_lat, input int lat0,
                               output int busy_cyc);
        int lat;
        lat      = lat0;
        busy_cyc = 0;
        while (w_en !== 1'b1 && lat < 60) begin
            if (busy === 1'b1) busy_cyc++;
            @(posedge clk); #1;
            lat++;
        end
        if (busy === 1'b1) busy_cyc++;
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check_result(tag);
        @(posedge clk); #1;
        check({tag, "_wen_pulse"}, 32'(w_en), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_wen"},  32'(w_en), 32'd0);
        check({tag, "_dest"}, 32'(DEST), 32'd0);
        check({tag, "_w_in"}, 32'(w_in), 32'd0);
        check({tag, "_hi"},   32'(hi),   32'd0);
        check({tag, "_dz"},   32'(dz),   32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc;
        int extra;
        logic             ro;
        logic [WIDTH-1:0] ra, rb;
        logic [RW-1:0]    rd;

        // Reset with start already high: nothing may be accepted during reset.
        reset = 1'b1; start = 1'b1; op = 1'b0; op0 = 16'd3; op1 = 16'd5; dest_in = 3'd2;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;
        issue(1'b0, 16'd3, 16'd5, 3'd2);
        wait_result("start_held_through_reset", 16, 0, bc);

        // Directed multiply cases.
        issue(1'b0, 16'h1234, 16'h0010, 3'd3);
        check("mul1_busy", 32'(busy), 32'd1);
        wait_result("mul1", 16, 0, bc);
        check("mul1_const_w_in", 32'(w_in), 32'h2340);
        check("mul1_const_hi",   32'(hi),   32'h0001);

        issue(1'b0, 16'hFFFF, 16'hFFFF, 3'd1);
        wait_result("mul_ffff", 16, 0, bc);
        check("mul_ffff_busy_cycles", 32'(bc), 32'd17);
        check("mul_ffff_w_in", 32'(w_in), 32'h0001);
        check("mul_ffff_hi",   32'(hi),   32'hFFFE);

        // Directed divide.
        issue(1'b1, 16'hAAAA, 16'h0003, 3'd5);
        wait_result("div1", 16, 0, bc);
        check("div1_const_w_in", 32'(w_in), 32'h38E3);
        check("div1_const_hi",   32'(hi),   32'h0001);

        // Divide by zero, start held high: DONE cycle ignores start, next
        // request lands two edges later.
        start = 1'b1; op = 1'b1; op1 = 16'h0000; op0 = 16'h1234; dest_in = 3'd4;
        push_exp(1'b1, 16'h1234, 16'h0000, 3'd4);
        @(posedge clk); #1;
        check_result("dz1");
        check("dz1_const_w_in", 32'(w_in), 32'hFFFF);
        op0 = 16'h00FF; dest_in = 3'd6;
        @(posedge clk); #1;
        check("dz_done_start_ignored_wen",  32'(w_en), 32'd0);
        check("dz_done_start_ignored_busy", 32'(busy), 32'd0);
        push_exp(1'b1, 16'h00FF, 16'h0000, 3'd6);
        @(posedge clk); #1;
        check_result("dz2");
        start = 1'b0;
        @(posedge clk); #1;
        check("dz2_idle", 32'(busy), 32'd0);

        // A second start mid-multiply must be dropped.
        issue(1'b0, 16'h1234, 16'h0010, 3'd3);
        repeat (4) begin @(posedge clk); #1; end
        start = 1'b1; op = 1'b1; op0 = 16'hFFFF; op1 = 16'h0007; dest_in = 3'd7;
        @(posedge clk); #1;
        start = 1'b0;
        wait_result("busy_start_ignored", 16, 5, bc);
        extra = 0;
        repeat (20) begin @(posedge clk); #1; if (w_en === 1'b1) extra++; end
        check("busy_start_no_second_wen", 32'(extra), 32'd0);

        // Destination 0 is forwarded unchanged.
        issue(1'b1, 16'd1000, 16'd7, 3'd0);
        wait_result("dest0", 16, 0, bc);

        // Reset in the middle of a divide.
        issue(1'b1, 16'hAAAA, 16'h0003, 3'd5);
        repeat (8) begin @(posedge clk); #1; end
        #2 reset = 1'b1;
        #1;
        check_all_zero("midrst_async");
        sb.delete();
        repeat (2) begin @(posedge clk); #1; check("midrst_no_wen", 32'(w_en), 32'd0); end
        reset = 1'b0;
        issue(1'b0, 16'h00C8, 16'h0101, 3'd2);
        wait_result("after_rst_mul", 16, 0, bc);

        // A few random operations of both kinds.
        for (int i = 0; i < 6; i++) begin
            ro = 1'(i);
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rd = RW'($urandom);
            issue(ro, ra, rb, rd);
            wait_result("rand", (ro && rb == 0) ? 0 : 16, 0, bc);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
